mem_initiator: RTL and testbench

Requester-side driver for the single-cycle verification memory port (req/we/addr/be/wdata out, 64-bit read data back). It accepts a stream of read/write commands through a valid/ready queue, issues them to the memory one per cycle, and returns read data through a valid/ready response queue. It sits between testbench stimulus (or a replay engine) and the memory model, and replaces ad-hoc direct driving of the memory pins.

---
 rtl/mem_initiator_pkg.sv | 18 +
 rtl/mem_initiator_fifo.sv | 51 +++++
 rtl/mem_initiator.sv | 104 ++++++++++
 tb/tb_mem_initiator.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_initiator_pkg.sv
// mem_initiator_pkg: shared widths and command/response records for the memory initiator
package mem_initiator_pkg;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int BE_W = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rsp_t;
endpackage

// File: rtl/mem_initiator_fifo.sv
// mem_initiator_fifo: synchronous FIFO with occupancy count, no pass-through when full
module mem_initiator_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [W-1:0]          data_i,
    input  logic                  pop_i,
    output logic [W-1:0]          data_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    // A pop never frees a slot for a push in the same cycle; pointers wrap naturally at DEPTH
    always_comb begin
        push_ok = push_i && count_q != CW'(DEPTH);
        pop_ok  = pop_i && count_q != '0;
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and occupancy state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; an entry is only read after it has been written
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: queued command driver for the single-cycle memory port with credit-limited read responses
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [BE_W-1:0]   cmd_be_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              req_o,
    output logic              enable_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [ADDR_W-1:0] rsp_addr_o,
    output logic              busy_o
);
    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;

    cmd_t            cmd_in, cmd_head;
    rsp_t            rsp_in, rsp_head;
    logic [CCW-1:0]  cmd_count;
    logic [RCW-1:0]  rsp_count;
    logic            head_valid, issue;
    logic            c_q, c_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign cmd_in = '{we: cmd_we_i, addr: cmd_addr_i, be: cmd_be_i, wdata: cmd_wdata_i};
    assign rsp_in = '{addr: addr_q, data: data_i};

    mem_initiator_fifo #(.DEPTH(CMD_DEPTH), .W($bits(cmd_t))) u_cmd_q (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (cmd_valid_i),
        .data_i (cmd_in),
        .pop_i  (issue),
        .data_o (cmd_head),
        .count_o(cmd_count)
    );

    mem_initiator_fifo #(.DEPTH(RSP_DEPTH), .W($bits(rsp_t))) u_rsp_q (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (c_q),
        .data_i (rsp_in),
        .pop_i  (rsp_valid_o && rsp_ready_i),
        .data_o (rsp_head),
        .count_o(rsp_count)
    );

    // Issue the head each cycle; a read needs a free response slot counting the read still in capture
    always_comb begin
        head_valid = cmd_count != '0;
        issue      = head_valid && (cmd_head.we || (rsp_count + RCW'(c_q)) < RCW'(RSP_DEPTH));
        c_d        = issue && !cmd_head.we;
        we_d       = issue ? cmd_head.we : we_q;
        addr_d     = issue ? cmd_head.addr : addr_q;
        be_d       = issue ? (cmd_head.we ? cmd_head.be : '0) : be_q;
        data_d     = issue ? cmd_head.wdata : data_q;
    end

    // Capture-stage tag and held memory-port values; addr_q doubles as the address of the read in capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_q    <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            be_q   <= '0;
            data_q <= '0;
        end else begin
            c_q    <= c_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            be_q   <= be_d;
            data_q <= data_d;
        end
    end

    assign cmd_ready_o = cmd_count != CCW'(CMD_DEPTH);
    assign req_o       = issue;
    assign enable_o    = issue;
    assign we_o        = we_d;
    assign addr_o      = addr_d;
    assign be_o        = be_d;
    assign data_o      = data_d;
    assign rsp_valid_o = rsp_count != '0;
    assign rsp_data_o  = rsp_valid_o ? rsp_head.data : '0;
    assign rsp_addr_o  = rsp_valid_o ? rsp_head.addr : '0;
    assign busy_o      = head_valid || c_q || rsp_valid_o;
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized self-checking bench with a shadow-memory response model
module tb_mem_initiator;
    logic clk = 0, rst_i = 1;
    logic cmd_valid_i = 0, cmd_we_i = 0, rsp_ready_i = 0;
    logic [63:0] cmd_addr_i = 0, cmd_wdata_i = 0, data_i = 0;
    logic [3:0] cmd_be_i = 0;
    logic cmd_ready_o, req_o, enable_o, we_o, rsp_valid_o, busy_o;
    logic [63:0] addr_o, data_o, rsp_data_o, rsp_addr_o;
    logic [3:0] be_o;

    typedef struct packed { logic [63:0] a; logic [63:0] d; } rsp_s;
    typedef struct packed { logic [31:0] c; logic we; logic [63:0] a; logic [3:0] be; } req_s;

    int checks = 0, errors = 0, cyc = 0, n_acc = 0;
    bit rnd_mode = 0;
    rsp_s exp_q[$], got_q[$];
    req_s req_log[$];
    logic [31:0] mem [logic [63:0]];
    logic [31:0] sh [logic [63:0]];

    mem_initiator #(.CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
        .req_o(req_o), .enable_o(enable_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o),
        .data_o(data_o), .data_i(data_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_addr_o(rsp_addr_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] dflt(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    function automatic logic [31:0] mrd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] srd(input logic [63:0] a);
        return sh.exists(a) ? sh[a] : dflt(a);
    endfunction

    // Memory model, accepted-command reference (shadow memory at accept time) and observation logs
    always @(posedge clk) begin
        if (!rst_i && cmd_valid_i && cmd_ready_o) begin
            n_acc++;
            if (cmd_we_i) sh[cmd_addr_i] = merge(srd(cmd_addr_i), cmd_wdata_i[31:0], cmd_be_i);
            else exp_q.push_back({cmd_addr_i, srd(cmd_addr_i), srd(cmd_addr_i + 64'd4)});
        end
        if (req_o) begin
            req_log.push_back({32'(cyc), we_o, addr_o, be_o});
            if (we_o) mem[addr_o] = merge(mrd(addr_o), data_o[31:0], be_o);
        end
        data_i <= (req_o && !we_o) ? {mrd(addr_o), mrd(addr_o + 64'd4)} : {$urandom, $urandom};
        if (!rst_i && rsp_valid_o && rsp_ready_i) got_q.push_back({rsp_addr_o, rsp_data_o});
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [63:0] a, input logic [3:0] be, input logic [63:0] d);
        int w = 0;
        cmd_we_i = we; cmd_addr_i = a; cmd_be_i = be; cmd_wdata_i = d; cmd_valid_i = 1;
        while (!cmd_ready_o && w < 200) begin
            if (rnd_mode) rsp_ready_i = $urandom_range(0, 3) != 0;
            tick();
            w++;
        end
        if (w >= 200) begin
            errors++;
            $display("FAIL push_timeout cmd_ready_o=%b want 1 within 200 cycles", cmd_ready_o);
        end
        tick();
        cmd_valid_i = 0;
    endtask

    task automatic drain();
        int w = 0;
        rsp_ready_i = 1;
        while (busy_o && w < 300) begin tick(); w++; end
    endtask

    function automatic logic [63:0] raddr();
        return 64'h1_0000_0000 + 64'($urandom_range(0, 15)) * 64'd4;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cmd_ready_o, req_o, enable_o, we_o, addr_o, be_o, data_o, rsp_valid_o, rsp_data_o, rsp_addr_o, busy_o} !== {1'b1, 265'b0}) begin
                errors++;
                $display("FAIL reset_values req=%b we=%b addr=%h be=%h data=%h rv=%b rd=%h ra=%h busy=%b rdy=%b want rdy=1 rest 0",
                         req_o, we_o, addr_o, be_o, data_o, rsp_valid_o, rsp_data_o, rsp_addr_o, busy_o, cmd_ready_o);
            end
        end
        rst_i = 0;
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release cmd_ready_o=%b busy_o=%b want 1 0", cmd_ready_o, busy_o);
        end
    endtask

    task automatic test_write_read();
        logic [63:0] a = 64'h1_0000_1040;
        bit saw_rsp = 0;
        rsp_s e;
        req_log.delete();
        rsp_ready_i = 0;
        push(1, a, 4'hF, 64'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin saw_rsp |= rsp_valid_o; tick(); end
        checks++;
        if (req_log.size() != 1 || saw_rsp) begin
            errors++;
            $display("FAIL wr_pulses got=%0d rsp=%b want 1 0", req_log.size(), saw_rsp);
        end else begin
            checks++;
            if (req_log[0].we !== 1'b1 || req_log[0].be !== 4'hF || req_log[0].a !== a) begin
                errors++;
                $display("FAIL wr_fields we=%b be=%h addr=%h want 1 f %h", req_log[0].we, req_log[0].be, req_log[0].a, a);
            end
        end
        push(0, a, 4'h0, 64'h0);
        checks++;
        if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rd_lat_c1 rsp_valid_o=%b want 0", rsp_valid_o); end
        tick();
        checks++;
        if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rd_lat_c2 rsp_valid_o=%b want 0", rsp_valid_o); end
        tick();
        e = exp_q.size() > 0 ? exp_q[0] : '0;
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o[63:32] !== 32'hDEADBEEF || rsp_addr_o !== a || rsp_data_o !== e.d) begin
            errors++;
            $display("FAIL rd_rsp valid=%b data=%h addr=%h want 1 %h %h", rsp_valid_o, rsp_data_o, rsp_addr_o, e.d, a);
        end
        drain();
        checks++;
        if (busy_o !== 1'b0 || got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL wr_rd_scoreboard busy=%b got=%0d want 1 entry", busy_o, got_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_credit_stall();
        rsp_ready_i = 0;
        req_log.delete();
        for (int i = 0; i < 6; i++) push(0, raddr(), 4'h0, 64'h0);
        repeat (8) tick();
        checks++;
        if (req_log.size() != 4 || req_o !== 1'b0) begin
            errors++;
            $display("FAIL credit_stall pulses=%0d req_o=%b want 4 0", req_log.size(), req_o);
        end
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;
        checks++;
        if (req_o !== 1'b1) begin errors++; $display("FAIL credit_release req_o=%b want 1", req_o); end
        repeat (5) tick();
        checks++;
        if (req_log.size() != 5) begin errors++; $display("FAIL credit_one_more pulses=%0d want 5", req_log.size()); end
        drain();
        checks++;
        if (busy_o !== 1'b0 || got_q.size() != exp_q.size() || exp_q.size() != 6) begin
            errors++;
            $display("FAIL credit_count busy=%b got=%0d want %0d", busy_o, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL credit_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_write_stream();
        logic [63:0] a[8];
        int nr = 0;
        rsp_ready_i = 1;
        req_log.delete();
        for (int i = 0; i < 8; i++) begin
            a[i] = 64'h2_0000_0000 + 64'(i) * 64'd4 + 64'($urandom_range(0, 3)) * 64'h100;
            if (cmd_ready_o !== 1'b1) nr++;
            push(1, a[i], 4'($urandom), {$urandom, $urandom});
        end
        repeat (3) tick();
        checks++;
        if (nr != 0 || req_log.size() != 8) begin
            errors++;
            $display("FAIL stream not_ready=%0d pulses=%0d want 0 8", nr, req_log.size());
        end
        for (int i = 0; i < req_log.size() && i < 8; i++) begin
            checks++;
            if (req_log[i].a !== a[i] || req_log[i].we !== 1'b1 || req_log[i].c !== req_log[0].c + 32'(i)) begin
                errors++;
                $display("FAIL stream[%0d] addr=%h we=%b cyc=%0d want %h 1 %0d", i, req_log[i].a, req_log[i].we, req_log[i].c, a[i], req_log[0].c + 32'(i));
            end
        end
    endtask

    task automatic test_full_queue();
        int n0;
        rsp_ready_i = 0;
        req_log.delete();
        for (int i = 0; i < 8; i++) push(0, raddr(), 4'h0, 64'h0);
        repeat (3) tick();
        checks++;
        if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready cmd_ready_o=%b want 0", cmd_ready_o); end
        n0 = n_acc;
        cmd_we_i = 1; cmd_addr_i = raddr(); cmd_be_i = 4'($urandom); cmd_wdata_i = {$urandom, $urandom}; cmd_valid_i = 1;
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;
        checks++;
        if (req_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_cycle req_o=%b cmd_ready_o=%b want 1 0", req_o, cmd_ready_o);
        end
        tick();
        checks++;
        if (n_acc != n0 || cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_no_pass accepted=%0d ready=%b want 0 1", n_acc - n0, cmd_ready_o);
        end
        tick();
        cmd_valid_i = 0;
        checks++;
        if (n_acc != n0 + 1) begin errors++; $display("FAIL full_accept accepted=%0d want 1", n_acc - n0); end
        drain();
        checks++;
        if (busy_o !== 1'b0 || req_log.size() != 9 || got_q.size() != exp_q.size() || exp_q.size() != 8) begin
            errors++;
            $display("FAIL full_count busy=%b pulses=%0d got=%0d want 0 9 8", busy_o, req_log.size(), got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        rnd_mode = 1;
        for (int i = 0; i < 150; i++) begin
            rsp_ready_i = $urandom_range(0, 3) != 0;
            push(1'($urandom_range(0, 1)), raddr(), 4'($urandom), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd_mode = 0;
        drain();
        checks++;
        if (busy_o !== 1'b0 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count busy=%b got=%0d want %0d", busy_o, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] a = raddr();
        logic [63:0] d = {$urandom, $urandom};
        int w = 0;
        bit saw = 0;
        rsp_ready_i = 1;
        push(0, raddr(), 4'h0, 64'h0);
        while (!req_o && w < 10) begin tick(); w++; end
        checks++;
        if (req_o !== 1'b1) begin errors++; $display("FAIL mid_read_issue req_o=%b want 1", req_o); end
        rst_i = 1;
        tick();
        rst_i = 0;
        checks++;
        if (req_o !== 1'b0) begin errors++; $display("FAIL mid_read_req req_o=%b want 0", req_o); end
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin saw |= rsp_valid_o; tick(); end
        checks++;
        if (saw || got_q.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_flush rsp_seen=%b got=%0d busy=%b want 0 0 0", saw, got_q.size(), busy_o);
        end
        push(1, a, 4'hF, d);
        push(0, a, 4'h0, 64'h0);
        drain();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0].d[63:32] !== d[31:0]) begin
            errors++;
            $display("FAIL mid_read_after got=%0d data=%h want 1 upper %h", got_q.size(), got_q.size() > 0 ? got_q[0].d : 64'h0, d[31:0]);
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_credit_stall();
        test_write_stream();
        test_full_queue();
        test_random();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
